// File: rtl/coin_acceptor.sv
// coin_acceptor
//   Cleans up the raw coin-slot sensors in front of the vend FSM. It
//   synchronises and debounces the two sensor levels and emits one-cycle
//   nickel_in / dime_in pulses. A reject pulse is emitted if both sensors are
//   active. After every coin the block waits for the sensors to release and
//   then holds off for a lockout window, so that the vend FSM has time to
//   return to S0. Two 8-bit saturating counters tally the accepted coins.
//
// Ports
//   clock         rising-edge system clock
//   reset         synchronous, active-high reset
//   nickel_raw    raw nickel sensor (asynchronous, bouncy)
//   dime_raw      raw dime sensor (asynchronous, bouncy)
//   dispense      dispense strobe from the vend FSM; extends the lockout
//   nickel_in     one-cycle accepted-nickel pulse (registered)
//   dime_in       one-cycle accepted-dime pulse (registered)
//   reject        one-cycle rejected-coin pulse (registered)
//   nickel_count  accepted nickels, saturating at 255
//   dime_count    accepted dimes, saturating at 255
//
// state        | meaning
// IDLE         | waiting for a single-sensor pattern
// QUALIFY      | counting consecutive matching samples
// EMIT         | accept pulse high this cycle
// REJECT       | reject pulse high this cycle
// WAIT_RELEASE | waiting for both sensors to read 0
// LOCKOUT      | post-release hold-off, sensors ignored
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       dispense,
  output logic       nickel_in,
  output logic       dime_in,
  output logic       reject,
  output logic [7:0] nickel_count,
  output logic [7:0] dime_count
);

  localparam logic [3:0] DEB  = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] LOCK = 4'(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    EMIT,
    REJECT,
    WAIT_RELEASE,
    LOCKOUT
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] sync_n_q, sync_d_q;
  logic [1:0] prime_q;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] coin_q, coin_d;
  logic       nickel_q, dime_q, reject_q;
  logic       nickel_d, dime_d, reject_d;
  logic [7:0] nickel_cnt_q, dime_cnt_q;
  logic [1:0] pat;

  assign pat = {sync_n_q[1], sync_d_q[1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    coin_d   = coin_q;
    nickel_d = 1'b0;
    dime_d   = 1'b0;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pat == 2'b11) begin
          state_d  = REJECT;
          reject_d = 1'b1;
        end else if (pat != 2'b00) begin
          coin_d = pat;
          cnt_d  = 4'd1;
          if (DEB == 4'd1) begin
            state_d  = EMIT;
            nickel_d = pat[1];
            dime_d   = pat[0];
          end else begin
            state_d = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (pat == coin_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == DEB) begin
            state_d  = EMIT;
            nickel_d = coin_q[1];
            dime_d   = coin_q[0];
          end
        end else if (pat == 2'b11) begin
          state_d  = REJECT;
          reject_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT, REJECT: state_d = WAIT_RELEASE;
      WAIT_RELEASE: begin
        // Right after reset the synchronizer still holds reset zeros. Those
        // zeros must not be mistaken for a release, or a coin held across
        // reset would be counted.
        if (prime_q[1] && pat == 2'b00) begin
          state_d = LOCKOUT;
          cnt_d   = 4'd0;
        end
      end
      LOCKOUT: begin
        if (dispense) begin
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == LOCK) state_d = IDLE;
        end
      end
      default: state_d = WAIT_RELEASE;
    endcase
  end

  // Pulses are registered on the edge that enters EMIT/REJECT, so they are
  // high exactly during that state's cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= WAIT_RELEASE;
      sync_n_q     <= 2'b00;
      sync_d_q     <= 2'b00;
      prime_q      <= 2'b00;
      cnt_q        <= 4'd0;
      coin_q       <= 2'b00;
      nickel_q     <= 1'b0;
      dime_q       <= 1'b0;
      reject_q     <= 1'b0;
      nickel_cnt_q <= 8'd0;
      dime_cnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      sync_n_q <= {sync_n_q[0], nickel_raw};
      sync_d_q <= {sync_d_q[0], dime_raw};
      prime_q  <= {prime_q[0], 1'b1};
      cnt_q    <= cnt_d;
      coin_q   <= coin_d;
      nickel_q <= nickel_d;
      dime_q   <= dime_d;
      reject_q <= reject_d;
      if (nickel_d && nickel_cnt_q != 8'hFF) nickel_cnt_q <= nickel_cnt_q + 8'd1;
      if (dime_d && dime_cnt_q != 8'hFF)     dime_cnt_q   <= dime_cnt_q + 8'd1;
    end
  end

  assign nickel_in    = nickel_q;
  assign dime_in      = dime_q;
  assign reject       = reject_q;
  assign nickel_count = nickel_cnt_q;
  assign dime_count   = dime_cnt_q;

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage that sits directly upstream of the Item_Two vending FSM. It turns raw, bouncy, asynchronous coin-slot sensor levels into clean, mutually exclusive, single-cycle nickel_in / dime_in pulses, and rejects ambiguous coins. It also enforces a post-coin lockout so that no coin pulse lands while the vend FSM is in its S20/S25 return-to-S0 cycle. Saturating per-denomination counters are provided for audit.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized samples of a stable single-sensor pattern required to accept a coin (legal range 1..15)
LOCKOUT_CYCLES, 2, cycles after sensor release during which new insertions are ignored (legal range 1..15)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
nickel_raw  input  1  raw nickel sensor level, asynchronous, may bounce
dime_raw  input  1  raw dime sensor level, asynchronous, may bounce
dispense  input  1  dispense strobe from the vend FSM
nickel_in  output  1  registered one-cycle pulse to the vend FSM: accepted nickel
dime_in  output  1  registered one-cycle pulse to the vend FSM: accepted dime
reject  output  1  registered one-cycle pulse: coin rejected (both sensors active)
nickel_count  output  8  accepted nickels, saturating at 255
dime_count  output  8  accepted dimes, saturating at 255

Behaviour:
- Sync: each raw input passes through a 2-flop synchronizer (s_n, s_d). The FSM samples only the synchronized values. Raw-to-sample latency is 2 edges.
- States: IDLE, QUALIFY, EMIT, REJECT, WAIT_RELEASE, LOCKOUT. A 4-bit counter cnt is shared by QUALIFY and LOCKOUT.
- Reset: FSM goes to WAIT_RELEASE. cnt, sync flops, nickel_in, dime_in, reject, nickel_count and dime_count are all 0. A coin held across reset is NOT counted and must be released first.
- IDLE:
  - {s_n,s_d}=10 or 01: latch the coin type and set cnt=1. Go to EMIT if DEBOUNCE_CYCLES==1, else go to QUALIFY.
  - 11: go to REJECT.
  - 00: stay in IDLE.
- QUALIFY, each edge:
  - Pattern equals the latched pattern: cnt++. When cnt reaches DEBOUNCE_CYCLES, go to EMIT.
  - Pattern is 11: go to REJECT.
  - Any other pattern: go to IDLE with no output.
- EMIT: lasts one cycle. Exactly one of nickel_in / dime_in is 1 during this cycle. The matching count is incremented, holding at 255. Next state is WAIT_RELEASE.
- REJECT: lasts one cycle with reject=1. Next state is WAIT_RELEASE.
- WAIT_RELEASE: stay until {s_n,s_d}=00 is sampled, then go to LOCKOUT with cnt=0.
- LOCKOUT:
  - cnt++ each edge; go to IDLE when cnt reaches LOCKOUT_CYCLES.
  - dispense=1 in any LOCKOUT cycle reloads cnt=0, so the lockout is extended.
  - Sensor activity is ignored.
- Outputs:
  - nickel_in, dime_in and reject are mutually exclusive and never high for two consecutive cycles.
  - Minimum spacing between two accepted-coin pulses is DEBOUNCE_CYCLES + LOCKOUT_CYCLES + 2 cycles, which guarantees the vend FSM is back in S0.
- Latency: raw held steady from before edge 0 gives the first sample at edge 2. The pulse is high in the cycle after edge DEBOUNCE_CYCLES+1; for the default (4) that is the cycle after edge 5.
- Bounce: any drop-out shorter than DEBOUNCE_CYCLES restarts qualification from IDLE. Only one pulse is issued per insertion, however long the sensor is held.
- Mid-operation reset: reset overrides all states the same cycle. A pulse in flight is cancelled; counts clear.

Test Plan:
1. Clean nickel: nickel_raw=1 for 10 cycles, then 0 -> nickel_in=1 for exactly 1 cycle (cycle after edge 5); nickel_count=1; dime_in and reject stay 0.
2. Bouncy dime: dime_raw toggles 1,0,1,1,0,1,1,1,1,1 then held -> exactly one dime_in pulse, after the final 4-sample stable run; dime_count=1.
3. Both sensors: nickel_raw=dime_raw=1 for 6 cycles -> reject=1 for 1 cycle; no nickel_in or dime_in; counts unchanged.
4. Lockout: dime accepted, then dime_raw reasserted 1 cycle after release with dispense pulsed in LOCKOUT -> no second pulse until the lockout expires; then a new dime is qualified normally.
5. Reset: assert reset while in QUALIFY with nickel_raw held high -> no pulse; counts=0; nickel_in appears only after release and a fresh insertion.
6. Saturation: 256 accepted nickels -> nickel_count=255 and holds; the nickel_in pulse is still issued.
